npc_generator: RTL and testbench

Next-PC generator for the RV32I single-issue core. It sits between decode/branch-compare and the PC register and produces the address of the next instruction from the current PC, decoded ALU code, immediate, rs1 value and branch-taken flag. The next-PC path is purely combinational. A small clocked side-path reports a registered redirect indication for pipeline flush control.

---
 rtl/npc_generator_pkg.sv | 39 +++
 rtl/npc_generator_target_sel.sv | 27 ++
 rtl/npc_generator.sv | 38 +++
 tb/tb_npc_generator.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/npc_generator_pkg.sv
// npc_generator_pkg: shared ALU operation codes and branch helpers for the RV32I core
package npc_generator_pkg;
    localparam int ALUCODE_W = 6;
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;
    localparam logic [ALUCODE_W-1:0] ALU_LUI   = 6'd0;
    localparam logic [ALUCODE_W-1:0] ALU_AUIPC = 6'd1;
    localparam logic [ALUCODE_W-1:0] ALU_ADD   = 6'd2;
    localparam logic [ALUCODE_W-1:0] ALU_SUB   = 6'd3;
    localparam logic [ALUCODE_W-1:0] ALU_SLL   = 6'd4;
    localparam logic [ALUCODE_W-1:0] ALU_SLT   = 6'd5;
    localparam logic [ALUCODE_W-1:0] ALU_SLTU  = 6'd6;
    localparam logic [ALUCODE_W-1:0] ALU_XOR   = 6'd7;
    localparam logic [ALUCODE_W-1:0] ALU_SRL   = 6'd8;
    localparam logic [ALUCODE_W-1:0] ALU_SRA   = 6'd9;
    localparam logic [ALUCODE_W-1:0] ALU_OR    = 6'd10;
    localparam logic [ALUCODE_W-1:0] ALU_AND   = 6'd11;
    localparam logic [ALUCODE_W-1:0] ALU_LB    = 6'd20;
    localparam logic [ALUCODE_W-1:0] ALU_LH    = 6'd21;
    localparam logic [ALUCODE_W-1:0] ALU_LW    = 6'd22;
    localparam logic [ALUCODE_W-1:0] ALU_LBU   = 6'd23;
    localparam logic [ALUCODE_W-1:0] ALU_LHU   = 6'd24;
    localparam logic [ALUCODE_W-1:0] ALU_SB    = 6'd25;
    localparam logic [ALUCODE_W-1:0] ALU_SH    = 6'd26;
    localparam logic [ALUCODE_W-1:0] ALU_SW    = 6'd27;
    localparam logic [ALUCODE_W-1:0] ALU_BEQ   = 6'd32;
    localparam logic [ALUCODE_W-1:0] ALU_BNE   = 6'd33;
    localparam logic [ALUCODE_W-1:0] ALU_BLT   = 6'd34;
    localparam logic [ALUCODE_W-1:0] ALU_BGE   = 6'd35;
    localparam logic [ALUCODE_W-1:0] ALU_BLTU  = 6'd36;
    localparam logic [ALUCODE_W-1:0] ALU_BGEU  = 6'd37;
    localparam logic [ALUCODE_W-1:0] ALU_JAL   = 6'd38;
    localparam logic [ALUCODE_W-1:0] ALU_JALR  = 6'd39;

    function automatic logic is_branch(input logic [ALUCODE_W-1:0] code);
        return code == ALU_BEQ || code == ALU_BNE || code == ALU_BLT ||
               code == ALU_BGE || code == ALU_BLTU || code == ALU_BGEU;
    endfunction
endpackage

// File: rtl/npc_generator_target_sel.sv
// npc_target_sel: combinational next-PC candidate computation and final select
module npc_target_sel
    import npc_generator_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ALUCODE_W = npc_generator_pkg::ALUCODE_W
) (
    input  logic [XLEN-1:0]      pc,
    input  logic [ALUCODE_W-1:0] alucode,
    input  logic [XLEN-1:0]      imm,
    input  logic [XLEN-1:0]      reg1dat,
    input  logic                 br_taken,
    output logic [XLEN-1:0]      seq_pc,
    output logic [XLEN-1:0]      npc
);
    logic [XLEN-1:0] rel_pc;
    logic [XLEN-1:0] jalr_sum;
    logic            take_rel;

    assign seq_pc   = pc + XLEN'(4);
    assign rel_pc   = pc + imm;
    assign jalr_sum = reg1dat + imm;
    assign take_rel = alucode == ALU_JAL || (is_branch(alucode) && br_taken == ENABLE);
    // Undefined codes fall through to the sequential address.
    assign npc = take_rel ? rel_pc :
                 alucode == ALU_JALR ? {jalr_sum[XLEN-1:1], 1'b0} : seq_pc;
endmodule

// File: rtl/npc_generator.sv
// npc_generator: next-PC selection with redirect/misalign flags and a registered flush request
module npc_generator
    import npc_generator_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ALUCODE_W = npc_generator_pkg::ALUCODE_W
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [XLEN-1:0]      pc,
    input  logic [ALUCODE_W-1:0] alucode,
    input  logic [XLEN-1:0]      imm,
    input  logic [XLEN-1:0]      reg1dat,
    input  logic                 br_taken,
    output logic [XLEN-1:0]      npc,
    output logic                 redirect,
    output logic                 misaligned,
    output logic                 redirect_q
);
    logic [XLEN-1:0] seq_pc;

    npc_target_sel #(.XLEN(XLEN), .ALUCODE_W(ALUCODE_W)) u_sel (
        .pc       (pc),
        .alucode  (alucode),
        .imm      (imm),
        .reg1dat  (reg1dat),
        .br_taken (br_taken),
        .seq_pc   (seq_pc),
        .npc      (npc)
    );

    assign redirect   = npc != seq_pc;
    assign misaligned = |npc[1:0];

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) redirect_q <= 1'b0;
        else       redirect_q <= redirect;
endmodule

// File: tb/tb_npc_generator.sv
// tb_npc_generator: scoreboard-driven bench for npc_generator
module tb_npc_generator;
    import npc_generator_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] pc, imm, reg1dat, npc;
    logic [5:0]  alucode;
    logic        br_taken, redirect, misaligned, redirect_q;

    typedef struct packed {
        logic [31:0] npc;
        logic        redirect;
        logic        misaligned;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total = 0;

    npc_generator #(.XLEN(32), .ALUCODE_W(6)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pc         (pc),
        .alucode    (alucode),
        .imm        (imm),
        .reg1dat    (reg1dat),
        .br_taken   (br_taken),
        .npc        (npc),
        .redirect   (redirect),
        .misaligned (misaligned),
        .redirect_q (redirect_q)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_npc(input logic [31:0] p, input logic [5:0] a,
                                            input logic [31:0] i, input logic [31:0] r,
                                            input logic b);
        logic [31:0] s;
        case (a)
            ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU: return b ? p + i : p + 32'd4;
            ALU_JAL:  return p + i;
            ALU_JALR: begin
                s = r + i;
                s[0] = 1'b0;
                return s;
            end
            default:  return p + 32'd4;
        endcase
    endfunction

    task automatic drive(input logic [31:0] p, input logic [5:0] a, input logic [31:0] i,
                         input logic [31:0] r, input logic b, input logic [31:0] e);
        pc = p;
        alucode = a;
        imm = i;
        reg1dat = r;
        br_taken = b;
        sb.push_back('{e, e != p + 32'd4, e[1:0] != 2'b00});
    endtask

    task automatic test_reset;
        exp_t x;
        drive(32'h0, ALU_BEQ, 32'd64, 32'h0, 1'b1, 32'd64);
        #1;
        x = sb.pop_front();
        total++;
        if (redirect_q !== 1'b0) $display("FAIL reset_redirect_q got %b expected 0", redirect_q);
        else passed++;
        total++;
        if (npc !== x.npc) $display("FAIL reset_npc got %h expected %h", npc, x.npc);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (redirect_q !== 1'b0) $display("FAIL reset_held_redirect_q got %b expected 0", redirect_q);
        else passed++;
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        total++;
        if (redirect_q !== 1'b1) $display("FAIL release_redirect_q got %b expected 1", redirect_q);
        else passed++;
    endtask

    task automatic test_vectors;
        exp_t x;
        logic [31:0] tp[8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0, 32'hFFFFFFFC};
        logic [5:0]  ta[8] = '{ALU_ADD, ALU_BEQ, ALU_BEQ, ALU_JAL, ALU_JAL, ALU_JALR, ALU_JALR, ALU_ADD};
        logic [31:0] ti[8] = '{32'd0, 32'd314, 32'd0, 32'd1592, 32'hFFFFFFF0, 32'd6535, 32'd6535, 32'd0};
        logic [31:0] tr[8] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd8979, 32'd8980, 32'd0};
        logic        tb[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] te[8] = '{32'd4, 32'd314, 32'd4, 32'd1592, 32'hF0, 32'd15514, 32'd15514, 32'd0};
        for (int k = 0; k < 8; k++) begin
            drive(tp[k], ta[k], ti[k], tr[k], tb[k], te[k]);
            #1;
            x = sb.pop_front();
            total++;
            if (npc !== x.npc) $display("FAIL vec%0d npc got %h expected %h", k, npc, x.npc);
            else passed++;
            total++;
            if (redirect !== x.redirect) $display("FAIL vec%0d redirect got %b expected %b", k, redirect, x.redirect);
            else passed++;
            total++;
            if (misaligned !== x.misaligned) $display("FAIL vec%0d misaligned got %b expected %b", k, misaligned, x.misaligned);
            else passed++;
        end
    endtask

    task automatic test_all_branches;
        exp_t x;
        logic [5:0] codes[6] = '{ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};
        for (int k = 0; k < 6; k++) begin
            for (int m = 0; m < 3; m++) begin
                // m: 0 taken far, 1 not taken, 2 taken with imm=4 (no redirect)
                drive(32'h1000, codes[k], m == 2 ? 32'd4 : 32'h40, 32'h55, m != 1,
                      m == 0 ? 32'h1040 : 32'h1004);
                #1;
                x = sb.pop_front();
                total++;
                if (npc !== x.npc) $display("FAIL br%0d_%0d npc got %h expected %h", k, m, npc, x.npc);
                else passed++;
                total++;
                if (redirect !== x.redirect) $display("FAIL br%0d_%0d redirect got %b expected %b", k, m, redirect, x.redirect);
                else passed++;
            end
        end
    endtask

    task automatic test_other_codes;
        exp_t x;
        logic [5:0] codes[6] = '{ALU_ADD, ALU_LW, ALU_SW, ALU_AUIPC, 6'h3F, 6'd50};
        for (int k = 0; k < 6; k++) begin
            drive(32'h2002, codes[k], 32'h80, 32'h9000, 1'b1, 32'h2006);
            #1;
            x = sb.pop_front();
            total++;
            if (npc !== x.npc) $display("FAIL seq%0d npc got %h expected %h", k, npc, x.npc);
            else passed++;
            total++;
            if (redirect !== x.redirect || misaligned !== x.misaligned)
                $display("FAIL seq%0d flags got %b%b expected %b%b", k, redirect, misaligned, x.redirect, x.misaligned);
            else passed++;
        end
    endtask

    task automatic test_random;
        exp_t x;
        logic [31:0] p, i, r;
        logic [5:0]  a;
        logic        b;
        for (int k = 0; k < 300; k++) begin
            p = $urandom;
            i = $urandom;
            r = $urandom;
            a = 6'($urandom_range(0, 63));
            b = 1'($urandom_range(0, 1));
            drive(p, a, i, r, b, ref_npc(p, a, i, r, b));
            #1;
            x = sb.pop_front();
            total++;
            if (npc !== x.npc || redirect !== x.redirect || misaligned !== x.misaligned)
                $display("FAIL rand%0d code=%0d npc got %h/%b/%b expected %h/%b/%b", k, a,
                         npc, redirect, misaligned, x.npc, x.redirect, x.misaligned);
            else passed++;
        end
    endtask

    task automatic test_redirect_q;
        @(negedge clk) drive(32'h40, ALU_ADD, 32'h0, 32'h0, 1'b0, 32'h44);
        void'(sb.pop_front());
        @(posedge clk); #1;
        total++;
        if (redirect_q !== 1'b0) $display("FAIL rq_seq got %b expected 0", redirect_q);
        else passed++;
        @(negedge clk) drive(32'h40, ALU_BNE, 32'h20, 32'h0, 1'b1, 32'h60);
        void'(sb.pop_front());
        @(posedge clk); #1;
        total++;
        if (redirect_q !== 1'b1) $display("FAIL rq_taken got %b expected 1", redirect_q);
        else passed++;
        #2 rstn = 1'b0;
        #1;
        total++;
        if (redirect_q !== 1'b0) $display("FAIL rq_async_reset got %b expected 0", redirect_q);
        else passed++;
        @(negedge clk) rstn = 1'b1;
        @(posedge clk); #1;
        total++;
        if (redirect_q !== 1'b1) $display("FAIL rq_after_release got %b expected 1", redirect_q);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_all_branches;
        test_other_codes;
        test_random;
        test_redirect_q;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
